// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and defaults for the register-file write-back controller.
// Holds the write-back source enum, default widths/arbitration limit and the request bundle.
package rf_ctrl_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int REG_N_DEF    = 32;
  localparam int AW_DEF       = $clog2(REG_N_DEF);
  localparam int MAX_WAIT_DEF = 2;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU
  } wb_src_e;

  typedef struct packed {
    logic [AW_DEF-1:0]     rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_if: ALU and LSU write-back valid/ready handshakes.
// master = producers (drive valid/rd/data), slave = controller (drives ready).
interface rf_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy vector of registers with an outstanding load.
// Ports: set (issue), clear (load return), two source lookups, busy vector out.
module rf_scoreboard #(
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic [N-1:0]  busy,
  output logic          src_busy
);

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;
  logic [N-1:0] set_m;
  logic [N-1:0] clr_m;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (set_en) set_m[set_rd] = 1'b1;
    if (clr_en) clr_m[clr_rd] = 1'b1;
    // set applied after clear so a same-cycle re-issue stays busy
    busy_d    = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign src_busy = busy_q[rs1] | busy_q[rs2];

endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: arbitrates the single RF write port between ALU and LSU, registers the write,
// tracks outstanding loads and flags decode hazards. Ports: clk, reset_n, wb (slave), issue_*, rs*, hazard, rf_*, busy.
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int mode       = DATA_W_DEF,
  parameter int reg_number = REG_N_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF,
  localparam int AW        = $clog2(reg_number)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rf_wb_if.slave                wb,
  input  logic                  issue_load,
  input  logic [AW-1:0]         issue_rd,
  input  logic [AW-1:0]         rs1_addr,
  input  logic [AW-1:0]         rs2_addr,
  output logic                  hazard,
  output logic                  rf_write,
  output logic [AW-1:0]         rf_sel_write_reg,
  output logic [mode-1:0]       rf_data_in,
  output logic [reg_number-1:0] busy
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;
  logic          starve;
  logic          alu_x;
  logic          lsu_x;
  wb_src_e       src;
  wb_req_t       req;
  wb_req_t       wb_q;
  wb_req_t       wb_d;
  logic          rf_write_q;
  logic          rf_write_d;
  logic          src_busy;
  logic          wr_hit;

  assign starve       = (wait_q == WW'(MAX_WAIT));
  assign wb.lsu_ready = reset_n & ~(wb.alu_valid & starve);
  assign wb.alu_ready = reset_n & (~wb.lsu_valid | starve);
  assign alu_x        = wb.alu_valid & wb.alu_ready;
  assign lsu_x        = wb.lsu_valid & wb.lsu_ready;

  always_comb begin
    wait_d = '0;
    if (wb.alu_valid && !wb.alu_ready)
      wait_d = starve ? wait_q : wait_q + 1'b1;
  end

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      alu_x:   src = SRC_ALU;
      lsu_x:   src = SRC_LSU;
      default: src = SRC_NONE;
    endcase
  end

  always_comb begin
    req = '0;
    unique case (src)
      SRC_ALU: begin
        req.rd   = AW_DEF'(wb.alu_rd);
        req.data = DATA_W_DEF'(wb.alu_data);
      end
      SRC_LSU: begin
        req.rd   = AW_DEF'(wb.lsu_rd);
        req.data = DATA_W_DEF'(wb.lsu_data);
      end
      default: req = '0;
    endcase
    // x0 writes are accepted but never reach the register file
    rf_write_d = (src != SRC_NONE) && (req.rd != '0);
    wb_d       = rf_write_d ? req : wb_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_q     <= '0;
      rf_write_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      wait_q     <= wait_d;
      rf_write_q <= rf_write_d;
      wb_q       <= wb_d;
    end
  end

  assign rf_write         = rf_write_q;
  assign rf_sel_write_reg = AW'(wb_q.rd);
  assign rf_data_in       = mode'(wb_q.data);

  rf_scoreboard #(
    .N  (reg_number),
    .AW (AW)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (issue_load && (issue_rd != '0)),
    .set_rd   (issue_rd),
    .clr_en   (lsu_x),
    .clr_rd   (wb.lsu_rd),
    .rs1      (rs1_addr),
    .rs2      (rs2_addr),
    .busy     (busy),
    .src_busy (src_busy)
  );

  // register file not yet written during the write-stage cycle
  assign wr_hit = rf_write_q && (rf_sel_write_reg != '0) &&
                  ((rf_sel_write_reg == rs1_addr) ||
                   (rf_sel_write_reg == rs2_addr));

  assign hazard = src_busy | wr_hit;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Drives at posedge+1, checks combinational outputs at posedge+2, registered ones at posedge+1.
module tb_rf_wb_ctrl;

  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_load;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        rf_write;
  logic [4:0]  rf_sel;
  logic [31:0] rf_din;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  rf_wb_if #(.DW(32), .AW(5)) wb ();

  rf_wb_ctrl #(
    .mode       (32),
    .reg_number (32),
    .MAX_WAIT   (MW)
  ) dut (
    .clk              (clk),
    .reset_n          (rst_n),
    .wb               (wb),
    .issue_load       (issue_load),
    .issue_rd         (issue_rd),
    .rs1_addr         (rs1),
    .rs2_addr         (rs2),
    .hazard           (hazard),
    .rf_write         (rf_write),
    .rf_sel_write_reg (rf_sel),
    .rf_data_in       (rf_din),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // behavioural model state
  bit          mbusy [32];
  int          streak;
  bit          mw;
  logic [4:0]  ma;
  logic [31:0] md;

  function automatic logic exp_alu_rdy();
    return rst_n && (!wb.lsu_valid || streak == MW);
  endfunction

  function automatic logic exp_lsu_rdy();
    return rst_n && !(wb.alu_valid && streak == MW);
  endfunction

  function automatic logic exp_hz();
    return mbusy[rs1] | mbusy[rs2] |
           (mw && ma != 0 && (ma == rs1 || ma == rs2));
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic tick();
    logic ax;
    logic lx;
    ax = wb.alu_valid && exp_alu_rdy();
    lx = wb.lsu_valid && exp_lsu_rdy();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 0;
      streak = 0;
      mw = 0;
      ma = '0;
      md = '0;
    end else begin
      if (wb.alu_valid && !ax) streak = (streak < MW) ? streak + 1 : MW;
      else                     streak = 0;
      if (lx) mbusy[wb.lsu_rd] = 0;
      if (issue_load && issue_rd != 0) mbusy[issue_rd] = 1;
      if (ax && wb.alu_rd != 0) begin
        mw = 1; ma = wb.alu_rd; md = wb.alu_data;
      end else if (lx && wb.lsu_rd != 0) begin
        mw = 1; ma = wb.lsu_rd; md = wb.lsu_data;
      end else begin
        mw = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    wb.alu_valid = 0;
    wb.lsu_valid = 0;
    issue_load   = 0;
  endtask

  task automatic test_reset();
    idle();
    tick();
    issue_load   = 1; issue_rd = 5'd3;
    wb.alu_valid = 1; wb.alu_rd = 5'd4; wb.alu_data = 32'hA5A5_0001;
    #1;
    checks++;
    if (wb.alu_ready !== 1'b1) begin
      errors++; $display("FAIL rst_pre_ardy got %b want 1", wb.alu_ready);
    end
    tick();
    issue_load = 0;
    checks++;
    if (rf_write !== 1'b1 || busy[3] !== 1'b1) begin
      errors++; $display("FAIL rst_pre_state got w=%b b3=%b want 1 1", rf_write, busy[3]);
    end
    rst_n = 0;
    wb.lsu_valid = 1; wb.lsu_rd = 5'd3;
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    checks++;
    if (wb.alu_ready !== 1'b0 || wb.lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got a=%b l=%b want 0 0", wb.alu_ready, wb.lsu_ready);
    end
    tick();
    checks++;
    if (busy !== 32'h0 || rf_write !== 1'b0) begin
      errors++; $display("FAIL rst_state got busy=%h w=%b want 0 0", busy, rf_write);
    end
    checks++;
    if (rf_sel !== 5'd0 || rf_din !== 32'h0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL rst_outs got sel=%0d din=%h hz=%b want 0 0 0", rf_sel, rf_din, hazard);
    end
    rst_n = 1;
    idle();
    rs1 = 0; rs2 = 0;
    tick();
  endtask

  task automatic test_priority();
    bit          pat [6] = '{0, 0, 1, 0, 0, 1};
    logic [4:0]  erd;
    logic [31:0] edat;
    idle();
    tick();
    for (int i = 0; i < 6; i++) begin
      wb.alu_valid = 1; wb.lsu_valid = 1;
      wb.alu_rd    = 5'($urandom_range(1, 31));
      wb.lsu_rd    = 5'($urandom_range(1, 31));
      wb.alu_data  = $urandom;
      wb.lsu_data  = $urandom;
      erd  = pat[i] ? wb.alu_rd : wb.lsu_rd;
      edat = pat[i] ? wb.alu_data : wb.lsu_data;
      #1;
      checks++;
      if (wb.alu_ready !== pat[i] || wb.lsu_ready !== !pat[i]) begin
        errors++;
        $display("FAIL prio_%0d got a=%b l=%b want a=%b", i,
                 wb.alu_ready, wb.lsu_ready, pat[i]);
      end
      tick();
      checks++;
      if (rf_write !== 1'b1 || rf_sel !== erd || rf_din !== edat) begin
        errors++;
        $display("FAIL prio_wr_%0d got %b %0d %h want 1 %0d %h", i,
                 rf_write, rf_sel, rf_din, erd, edat);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_hazard();
    idle();
    rs1 = 0; rs2 = 0;
    tick();
    issue_load = 1; issue_rd = 5'd5;
    tick();
    issue_load = 0;
    rs1 = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (busy[5] !== 1'b1 || hazard !== 1'b1) begin
        errors++; $display("FAIL hz_wait_%0d got b5=%b hz=%b want 1 1", i, busy[5], hazard);
      end
      tick();
    end
    wb.lsu_valid = 1; wb.lsu_rd = 5'd5; wb.lsu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (wb.lsu_ready !== 1'b1) begin
      errors++; $display("FAIL hz_lrdy got %b want 1", wb.lsu_ready);
    end
    tick();
    wb.lsu_valid = 0;
    #1;
    checks++;
    if (busy[5] !== 1'b0 || hazard !== 1'b1) begin
      errors++; $display("FAIL hz_wstage got b5=%b hz=%b want 0 1", busy[5], hazard);
    end
    checks++;
    if (rf_write !== 1'b1 || rf_sel !== 5'd5 || rf_din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hz_write got %b %0d %h want 1 5 deadbeef", rf_write, rf_sel, rf_din);
    end
    tick();
    #1;
    checks++;
    if (hazard !== 1'b0 || rf_write !== 1'b0) begin
      errors++; $display("FAIL hz_drop got hz=%b w=%b want 0 0", hazard, rf_write);
    end
    rs1 = 0;
  endtask

  task automatic test_set_wins();
    idle();
    issue_load = 1; issue_rd = 5'd7;
    tick();
    wb.lsu_valid = 1; wb.lsu_rd = 5'd7; wb.lsu_data = $urandom;
    tick();
    idle();
    checks++;
    if (busy[7] !== 1'b1) begin
      errors++; $display("FAIL set_wins got b7=%b want 1", busy[7]);
    end
    wb.lsu_valid = 1;
    tick();
    idle();
    checks++;
    if (busy[7] !== 1'b0) begin
      errors++; $display("FAIL set_clear got b7=%b want 0", busy[7]);
    end
    tick();
  endtask

  task automatic test_x0();
    logic [31:0] snap;
    idle();
    issue_load = 1; issue_rd = 5'd9;
    tick();
    issue_load = 0;
    tick();
    snap = exp_busy();
    wb.alu_valid = 1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1234;
    #1;
    checks++;
    if (wb.alu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ardy got %b want 1", wb.alu_ready);
    end
    tick();
    idle();
    checks++;
    if (rf_write !== 1'b0 || busy !== snap) begin
      errors++; $display("FAIL x0_alu got w=%b busy=%h want 0 %h", rf_write, busy, snap);
    end
    issue_load = 1; issue_rd = 5'd0;
    tick();
    idle();
    checks++;
    if (busy[0] !== 1'b0 || busy !== snap) begin
      errors++; $display("FAIL x0_issue got busy=%h want %h", busy, snap);
    end
  endtask

  task automatic test_reset_alu();
    idle();
    tick();
    wb.alu_valid = 1; wb.lsu_valid = 1;
    wb.alu_rd = 5'd11; wb.lsu_rd = 5'd12;
    tick();
    wb.lsu_valid = 0;
    wb.alu_data = 32'h0BAD_F00D;
    rst_n = 0;
    tick();
    rst_n = 1;
    idle();
    #1;
    checks++;
    if (rf_write !== 1'b0) begin
      errors++; $display("FAIL rst_alu_wr got %b want 0", rf_write);
    end
    wb.alu_valid = 1; wb.lsu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wb.alu_ready !== (i == 2)) begin
        errors++;
        $display("FAIL rst_alu_cnt_%0d got ardy=%b want %b", i, wb.alu_ready, (i == 2));
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] r;
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      wb.alu_valid = $urandom_range(0, 1);
      wb.lsu_valid = $urandom_range(0, 1);
      wb.alu_rd    = 5'($urandom_range(0, 31));
      wb.lsu_rd    = 5'($urandom_range(0, 31));
      wb.alu_data  = $urandom;
      wb.lsu_data  = $urandom;
      rs1          = 5'($urandom_range(0, 31));
      rs2          = 5'($urandom_range(0, 31));
      r            = 5'($urandom_range(0, 31));
      issue_rd     = r;
      issue_load   = ($urandom_range(0, 2) == 0) && !mbusy[r];
      #1;
      checks++;
      if (wb.alu_ready !== exp_alu_rdy() || wb.lsu_ready !== exp_lsu_rdy()) begin
        errors++;
        $display("FAIL rnd_rdy_%0d got a=%b l=%b want a=%b l=%b", n,
                 wb.alu_ready, wb.lsu_ready, exp_alu_rdy(), exp_lsu_rdy());
      end
      checks++;
      if (hazard !== exp_hz()) begin
        errors++; $display("FAIL rnd_hz_%0d got %b want %b", n, hazard, exp_hz());
      end
      tick();
      checks++;
      if (rf_write !== mw || rf_sel !== ma || rf_din !== md) begin
        errors++;
        $display("FAIL rnd_wr_%0d got %b %0d %h want %b %0d %h", n,
                 rf_write, rf_sel, rf_din, mw, ma, md);
      end
      checks++;
      if (busy !== exp_busy()) begin
        errors++; $display("FAIL rnd_busy_%0d got %h want %h", n, busy, exp_busy());
      end
    end
    rst_n = 1;
    idle();
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle();
    issue_rd = 0; rs1 = 0; rs2 = 0;
    wb.alu_rd = 0; wb.lsu_rd = 0; wb.alu_data = 0; wb.lsu_data = 0;
    for (int i = 0; i < 32; i++) mbusy[i] = 0;
    streak = 0; mw = 0; ma = 0; md = 0;
    #1;
    tick();
    tick();
    rst_n = 1;
    tick();
    test_reset();
    test_priority();
    test_hazard();
    test_set_wins();
    test_x0();
    test_reset_alu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller for the register file: shares its single write port between the ALU and the load/store unit (LSU), tracks registers with outstanding loads, and raises a read hazard for the decode stage. Sits between the execute/memory stages and the register file. Write-back to the register file goes through one registered pipeline stage. Writes to x0 are handshaken but never issued to the register file.

## Interface
- `mode`, 32, data width.
- `reg_number`, 32, number of architectural registers; `AW = $clog2(reg_number)`.
- `MAX_WAIT`, 2, consecutive ALU-blocked cycles before the ALU takes priority (≥1).

- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `alu_valid`  in  1  ALU write-back request.
- `alu_rd`  in  AW  ALU destination register.
- `alu_data`  in  mode  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `lsu_valid`  in  1  load data return request.
- `lsu_rd`  in  AW  load destination register.
- `lsu_data`  in  mode  load data.
- `lsu_ready`  out  1  LSU request accepted this cycle.
- `issue_load`  in  1  a load is issued this cycle; mark `issue_rd` busy.
- `issue_rd`  in  AW  destination of the issued load.
- `rs1_addr`, `rs2_addr`  in  AW  decode-stage source registers.
- `hazard`  out  1  decode must stall.
- `rf_write`  out  1  register file write enable (registered).
- `rf_sel_write_reg`  out  AW  register file write address (registered).
- `rf_data_in`  out  mode  register file write data (registered).
- `busy`  out  reg_number  scoreboard vector; bit i set means a load to xi is outstanding.

## Operation
- A transfer occurs when valid and ready are both high at a rising edge. At most one transfer per cycle.
- Arbitration:
  - Default priority is LSU first.
  - `starve` is asserted when `wait_cnt == MAX_WAIT`.
  - `lsu_ready = reset_n & ~(alu_valid & starve)`.
  - `alu_ready = reset_n & (~lsu_valid | starve)`.
  - Neither ready depends on its own valid.
- Wait counter (`wait_cnt`, saturating at MAX_WAIT):
  - Increments when `alu_valid & ~alu_ready`.
  - Clears on an ALU transfer or when `alu_valid` is low.
  - Holds otherwise.
- Write stage, on a transfer with rd ≠ 0:
  - Next cycle: `rf_write=1`, `rf_sel_write_reg=rd`, `rf_data_in=data`.
  - With no transfer, or with rd = 0: next cycle `rf_write=0`, and address/data hold their previous values.
- Scoreboard:
  - `issue_load` with `issue_rd ≠ 0` sets `busy[issue_rd]`.
  - An LSU transfer clears `busy[lsu_rd]`.
  - If a set and a clear hit the same register in the same cycle, set wins.
  - Issuing to an already-busy register leaves it busy. Only one outstanding load per register is permitted; the issuer enforces this.
  - `busy[0]` is constant 0.
  - An ALU transfer never changes `busy`.
- Hazard: `hazard = busy[rs1] | busy[rs2] | (rf_write & rf_sel_write_reg ≠ 0 & rf_sel_write_reg ∈ {rs1, rs2})`. The last term covers the cycle where the register file has not yet been written.

## Timing
- Reset: at a rising edge with `reset_n=0`, the following clear to 0: `busy`, `wait_cnt`, `rf_write`, `rf_sel_write_reg`, `rf_data_in`. While `reset_n=0`, both ready outputs are 0. `hazard` follows the cleared state (0 the cycle after reset).
- Reset mid-operation: any transfer presented in the reset cycle is dropped, and outstanding busy bits are lost. Upstream must flush in the same reset.
- Latency: transfer at edge E → `rf_write` high during cycle E..E+1 → register file updated at edge E+1.
- Clear-to-read: `busy` clears at edge E, and the write-stage term keeps `hazard` high through the cycle before edge E+1. Decode reads the new value from cycle E+1 onward.
- Starvation bound: a continuously valid ALU request is accepted within MAX_WAIT+1 cycles.

## Structure
- Package `rf_ctrl_pkg` holds:
  - `wb_src_e` enum: SRC_NONE, SRC_ALU, SRC_LSU.
  - Default MAX_WAIT constant.
  - `wb_req_t` struct (rd, data).
- Sub-module `rf_scoreboard` contains the busy vector with set/clear/lookup. Arbitration, counter and write stage stay in the top level.

## Test plan
- Reset with `busy` nonzero and `rf_write=1` → the cycle after reset, all outputs are 0 and both readies are 0 while reset_n=0.
- ALU and LSU both valid continuously, MAX_WAIT=2 → LSU, LSU, ALU, LSU, LSU, ALU pattern; `rf_write` follows one cycle later with the matching rd/data.
- `issue_load` rd=5 → `busy[5]=1`. `rs1_addr=5` gives `hazard=1` until the LSU transfer rd=5, data=0xDEADBEEF. `hazard` stays 1 for one further cycle (write stage), then drops as `rf_write` with 0xDEADBEEF completes.
- `issue_load` rd=7 in the same cycle as an LSU transfer rd=7 → `busy[7]` remains 1.
- ALU transfer rd=0, data=0x1234 → `alu_ready=1`, `rf_write` stays 0, `busy` unchanged; `issue_load` rd=0 leaves `busy[0]=0`.
- Reset asserted the same cycle as an ALU transfer → no `rf_write` afterwards, `wait_cnt=0`.
